// File: rtl/zliczanie_bufor_wyj.sv
// ---------------------------------------------------------------------------
// Module : zliczanie_bufor_wyj
// Brief  : 2-entry skid buffer for ones-count results with entry flags and a
//          saturating running sum of all accepted counts.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module zliczanie_bufor_wyj #(
  parameter int BITS     = 2,
  parameter int SUM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITS-1:0]     i_result,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [BITS-1:0]     o_result,
  output logic                o_flag_zero,
  output logic                o_flag_max,
  output logic                o_valid,
  input  logic                i_ready,
  input  logic                i_clear_sum,
  output logic [SUM_BITS-1:0] o_suma,
  output logic                o_sat
);

  localparam int ENTRY_W = BITS + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   main_q, main_d;
  logic [ENTRY_W-1:0]   skid_q, skid_d;
  logic [SUM_BITS-1:0]  suma_q, suma_d;
  logic                 sat_q, sat_d;

  logic                 w_acc;
  logic                 w_rel;
  logic [ENTRY_W-1:0]   w_entry;
  logic [SUM_BITS:0]    w_base;
  logic [SUM_BITS:0]    w_sum;

  // Entry layout: {result, zero, max}; flags are captured at accept time.
  assign w_entry = {i_result, (i_result == '0), (i_result == '1)};

  assign o_ready     = !i_rst && (state_q != S_TWO);
  assign o_valid     = (state_q != S_EMPTY);
  assign o_result    = main_q[ENTRY_W-1:2];
  assign o_flag_zero = main_q[1];
  assign o_flag_max  = main_q[0];
  assign o_suma      = suma_q;
  assign o_sat       = sat_q;

  assign w_acc = i_valid && o_ready;
  assign w_rel = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (w_acc) begin
          state_d = S_ONE;
          main_d  = w_entry;
        end
      end
      S_ONE: begin
        if (w_acc && !w_rel) begin
          state_d = S_TWO;
          skid_d  = w_entry;
        end else if (w_rel && !w_acc) begin
          state_d = S_EMPTY;
        end else if (w_acc && w_rel) begin
          main_d  = w_entry;
        end
      end
      S_TWO: begin
        if (w_rel) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Clear zeroes the base first so a coincident accept starts from zero.
  always_comb begin
    w_base = i_clear_sum ? '0 : {1'b0, suma_q};
    w_sum  = w_base + {{(SUM_BITS + 1 - BITS){1'b0}}, i_result};
    suma_d = suma_q;
    sat_d  = sat_q;
    if (i_clear_sum) begin
      suma_d = '0;
      sat_d  = 1'b0;
    end
    if (w_acc) begin
      if (w_sum[SUM_BITS]) begin
        suma_d = '1;
        sat_d  = 1'b1;
      end else begin
        suma_d = w_sum[SUM_BITS-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      suma_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      suma_q  <= suma_d;
      sat_q   <= sat_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zliczanie_bufor_wyj.sv
// ---------------------------------------------------------------------------
// Module : tb_zliczanie_bufor_wyj
// Brief  : Directed self-checking bench for zliczanie_bufor_wyj (BITS=2, SUM_BITS=4).
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_zliczanie_bufor_wyj;

  localparam int BITS     = 2;
  localparam int SUM_BITS = 4;

  logic                clk;
  logic                rst;
  logic [BITS-1:0]     result_i;
  logic                valid_i;
  logic                ready_o;
  logic [BITS-1:0]     result_o;
  logic                flag_zero_o;
  logic                flag_max_o;
  logic                valid_o;
  logic                ready_i;
  logic                clear_i;
  logic [SUM_BITS-1:0] suma_o;
  logic                sat_o;

  int n_vec;
  int n_err;

  zliczanie_bufor_wyj #(
    .BITS     (BITS),
    .SUM_BITS (SUM_BITS)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_result    (result_i),
    .i_valid     (valid_i),
    .o_ready     (ready_o),
    .o_result    (result_o),
    .o_flag_zero (flag_zero_o),
    .o_flag_max  (flag_max_o),
    .o_valid     (valid_o),
    .i_ready     (ready_i),
    .i_clear_sum (clear_i),
    .o_suma      (suma_o),
    .o_sat       (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sum;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    valid_i  = 1'b1;
    result_i = 2'd3;
    ready_i  = 1'b0;
    clear_i  = 1'b0;

    // Reset held two cycles with a valid offer present
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_o, 0);
      chk("rst_suma", suma_o, 0);
      chk("rst_sat", sat_o, 0);
    end
    rst     = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_valid", valid_o, 0);

    // Streaming 0..3 with i_ready held high
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid_i  = 1'b1;
      result_i = BITS'(k);
      step();
      chk("str_valid", valid_o, 1);
      chk("str_result", result_o, k);
      chk("str_zero", flag_zero_o, (k == 0));
      chk("str_max", flag_max_o, (k == 3));
      chk("str_ready", ready_o, 1);
    end
    valid_i = 1'b0;
    step();
    chk("str_drain", valid_o, 0);
    chk("str_suma", suma_o, 6);

    // Backpressure: offer 1,2,3 with i_ready low
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    result_i = 2'd1;
    step();
    chk("bp_ready1", ready_o, 1);
    result_i = 2'd2;
    step();
    chk("bp_ready2", ready_o, 0);
    chk("bp_head1", result_o, 1);
    result_i = 2'd3;
    step();
    chk("bp_hold_ready", ready_o, 0);
    chk("bp_hold_head", result_o, 1);
    chk("bp_hold_valid", valid_o, 1);
    ready_i = 1'b1;
    step();
    chk("bp_out2", result_o, 2);
    chk("bp_out2_valid", valid_o, 1);
    chk("bp_ready_back", ready_o, 1);
    step();
    chk("bp_out3", result_o, 3);
    chk("bp_out3_max", flag_max_o, 1);
    valid_i = 1'b0;
    step();
    chk("bp_drain", valid_o, 0);
    chk("bp_suma", suma_o, 12);
    chk("bp_sat", sat_o, 0);

    // Clear without accept
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_suma", suma_o, 0);
    chk("clr_sat", sat_o, 0);

    // Alternating valid with i_ready high never fills the skid
    for (int i = 0; i < 6; i++) begin
      valid_i  = (i % 2 == 0);
      result_i = 2'd1;
      step();
      chk("alt_ready", ready_o, 1);
      chk("alt_valid", valid_o, (i % 2 == 0));
    end
    valid_i = 1'b0;
    step();
    chk("alt_suma", suma_o, 3);

    // Saturation: six accepts of 3 into a 4-bit sum
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("sat_clr", suma_o, 0);
    for (int k = 1; k <= 6; k++) begin
      valid_i  = 1'b1;
      result_i = 2'd3;
      step();
      exp_sum = (3 * k > 15) ? 15 : 3 * k;
      chk("sat_suma", suma_o, exp_sum);
      chk("sat_flag", sat_o, (3 * k > 15));
    end
    clear_i  = 1'b1;
    result_i = 2'd2;
    step();
    clear_i = 1'b0;
    valid_i = 1'b0;
    chk("clr_acc_suma", suma_o, 2);
    chk("clr_acc_sat", sat_o, 0);
    chk("clr_acc_head", result_o, 2);
    step();
    chk("clr_acc_drain", valid_o, 0);

    // Reset with two entries in flight
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    result_i = 2'd1;
    step();
    result_i = 2'd2;
    step();
    chk("mid_full", ready_o, 0);
    valid_i = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", valid_o, 0);
    chk("mid_suma", suma_o, 0);
    chk("mid_ready", ready_o, 1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_old", valid_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zliczanie_bufor_wyj.md
# zliczanie_bufor_wyj

Output stage placed directly downstream of the combinational ones-counting stage of the ALU. It registers each count result with per-entry status flags in a 2-entry skid buffer with valid/ready handshakes on both sides. It also keeps a saturating running sum of all accepted counts. This breaks the combinational path between the counting logic and the result consumer, and stalls cleanly under backpressure.

## Interface
- BITS, 2, width of the count result; must match the counting stage's `o_result` width
- SUM_BITS, 8, width of the running-sum accumulator; must be ≥ BITS
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_result  input  BITS  count value from the counting stage
- i_valid  input  1  i_result is valid this cycle
- o_ready  output  1  stage can accept; `!i_rst && state != TWO`
- o_result  output  BITS  buffered count, head of buffer
- o_flag_zero  output  1  head entry count == 0
- o_flag_max  output  1  head entry count == all ones
- o_valid  output  1  head entry is valid
- i_ready  input  1  consumer accepts head entry this cycle
- i_clear_sum  input  1  clear running sum and saturation flag
- o_suma  output  SUM_BITS  saturating sum of all accepted i_result values
- o_sat  output  1  sticky; set when any accumulation saturated

## Operation
- Accept: `acc = i_valid && o_ready`. Release: `rel = o_valid && i_ready`.
- Each buffer entry stores {result, zero, max}. Flags are computed from i_result at accept time, not at the output.
- State machine:
  - EMPTY: o_valid = 0. On acc, go to ONE and load main.
  - ONE: main register valid.
    - acc && !rel: go to TWO, load skid.
    - rel && !acc: go to EMPTY.
    - acc && rel: stay in ONE, load main with the new entry.
  - TWO: main and skid valid; o_ready = 0 and i_valid is ignored. On rel, go to ONE with main <= skid.
- Order is strictly FIFO. No entry is dropped or duplicated.
- Outputs o_result, o_flag_zero and o_flag_max always reflect the main register. Their values are don't-care when o_valid = 0, but the bench checks them only when o_valid = 1.
- Accumulator:
  - On acc: `o_suma <= min(o_suma + i_result, 2^SUM_BITS-1)`. The sum is computed at SUM_BITS+1 width.
  - If the unclipped sum exceeds 2^SUM_BITS-1, set o_sat.
  - A result landing exactly on the maximum does not set o_sat.
- i_clear_sum:
  - Without a coincident acc: o_suma <= 0, o_sat <= 0.
  - With a coincident acc: clear takes precedence, then the add applies, so o_suma <= i_result and o_sat <= 0.
- i_clear_sum does not affect the buffer.
- Reset:
  - State goes to EMPTY.
  - o_valid = 0, o_suma = 0, o_sat = 0, main and skid data/flags = 0.
  - o_ready = 0 while i_rst is high.
  - Reset asserted with entries in flight discards them. The next cycle shows o_valid = 0.

## Timing
- Latency: an entry accepted at edge N is visible with o_valid = 1 after edge N, i.e. in cycle N+1. There is no combinational path from i_result or i_valid to any output.
- o_ready depends only on the state register and i_rst. There is no combinational path from i_ready to o_ready.
- Throughput: 1 entry/cycle when i_ready is held high.
- After i_ready drops, exactly one more entry can be absorbed (the skid) before o_ready falls.
- o_suma and o_sat update on the same edge as the accept; the new value is visible in cycle N+1.
- First accept is possible in the first cycle after i_rst deasserts.

## Test plan
- Reset behaviour, with BITS=2, SUM_BITS=4: hold i_rst 2 cycles with i_valid=1, i_result=3 -> o_valid=0, o_ready=0, o_suma=0, o_sat=0 throughout. The cycle after release: o_ready=1, o_valid=0.
- Streaming: i_ready=1, feed 0,1,2,3 on consecutive cycles -> o_result 0,1,2,3 on the following consecutive cycles. Flags: zero=1 only for 0, max=1 only for 3. o_suma = 6.
- Backpressure: i_ready=0, offer 1,2,3 on consecutive cycles -> 1 and 2 accepted, o_ready=0 from the third cycle, 3 held by upstream. Raise i_ready -> output 1,2,3 in order, none lost or duplicated.
- Simultaneous accept/release in ONE, with i_ready=1: alternating i_valid pattern -> state never reaches TWO, o_ready stays 1.
- Saturation: feed 3 six times (sum 18 > 15) -> o_suma=15 and o_sat=1 from the sixth accept. Then assert i_clear_sum together with an accept of 2 -> o_suma=2, o_sat=0.
- Reset mid-operation: fill to TWO, assert i_rst for 1 cycle -> o_valid=0, state EMPTY, old entries never appear at the output, o_suma=0.
